twelve_hour_timekeeper: RTL and testbench
=========================================

Name: twelve_hour_timekeeper

Overview:
- Synchronous timekeeper that consumes a single-cycle tick enable from the upstream divider chain and maintains 12-hour BCD time (hh:mm:ss plus AM/PM).
- An internal mod-DIV prescaler converts raw ticks to seconds.
- A small run/stop FSM and a valid/ready set port sit in front of display and alarm logic.
- All state is registered on one clock edge; there are no ripple-clocked stages.

Parameters:
- DIV, 12, raw ticks per second (>=1); prescaler width is $clog2(DIV), minimum 1.

Ports:
- clk  in  1  system clock, rising edge
- neg_clear  in  1  asynchronous active-low reset
- tick  in  1  one-cycle count enable from upstream divider
- start  in  1  request RUNNING (level sampled each cycle)
- stop  in  1  request STOPPED (level sampled each cycle)
- set_valid  in  1  time-load request
- set_ready  out  1  load accepted this cycle when high with set_valid
- set_hour  in  8  BCD hour {tens[7:4], units[3:0]}, legal 01..12
- set_min  in  8  BCD minute, legal 00..59
- set_pm  in  1  PM flag to load
- set_err  out  1  one-cycle pulse: handshake fired with illegal BCD
- hour  out  8  BCD hour 01..12
- min  out  8  BCD minute 00..59
- sec  out  8  BCD second 00..59
- pm  out  1  0=AM, 1=PM
- running  out  1  high in RUNNING
- sec_pulse  out  1  one-cycle pulse when seconds advance
- hour_pulse  out  1  one-cycle pulse when hour advances

Behaviour:
- Reset (neg_clear=0, takes effect immediately, not on the clock):
  - hour=8'h12, min=8'h00, sec=8'h00, pm=0, prescaler=0, state=STOPPED.
  - running=0, set_err=0, sec_pulse=0, hour_pulse=0.
- FSM states STOPPED and RUNNING:
  - STOPPED -> RUNNING on start.
  - RUNNING -> STOPPED on stop.
  - start and stop high together: stop wins (go to or stay in STOPPED).
- Prescaler:
  - Counts a tick only in RUNNING; ticks in STOPPED are ignored and the prescaler holds.
  - When tick=1 and prescaler==DIV-1: prescaler goes to 0 and seconds advance.
  - Otherwise tick increments the prescaler.
  - DIV=1: every tick advances seconds.
- Latency: time outputs and sec_pulse update on the clock edge that samples the qualifying tick. They are visible the following cycle.
- BCD arithmetic:
  - Units digit 9 -> 0 with carry into tens.
  - sec 59 -> 00 carries into min; min 59 -> 00 carries into hour.
- Hour sequence is 12, 01, 02, …, 11, 12:
  - The 11 -> 12 step toggles pm.
  - The 12 -> 01 step does not toggle pm.
  - hour_pulse fires on every hour advance.
  - 11:59:59 PM -> 12:00:00 AM.
- Set handshake:
  - set_ready = 1 only in STOPPED; 0 in RUNNING.
  - Transfer happens when set_valid & set_ready.
  - Legal values: hour 01..12, min 00..59, all digits <= 9.
  - Legal transfer: load hour/min/pm, clear sec and prescaler.
  - Illegal transfer: time unchanged, set_err=1 for exactly one cycle.
- Simultaneous events:
  - Set and start in the same STOPPED cycle: load (if legal) and go to RUNNING. A tick in that cycle is ignored.
  - stop and a qualifying tick in the same RUNNING cycle: the tick is counted, then the FSM stops.
- Reset during a set or a carry chain aborts it; all outputs return to reset values immediately.
- Outputs are registered; no combinational path from tick to the time outputs.

Decomposition:
- Package timekeeper_pkg:
  - Constants SEC_MAX=8'h59, MIN_MAX=8'h59, HOUR_MIN=8'h01, HOUR_MAX=8'h12, HOUR_RST=8'h12.
  - State enum {ST_STOPPED, ST_RUNNING}.
  - BCD-legality function.
- One sub-module, bcd_pair_counter:
  - Two-digit BCD counter with parameterised low/high bounds, enable, synchronous load, and carry-out.
  - Instantiated three times: sec, min, hour (hour with bounds 01..12).
  - pm toggle and the FSM stay in the top level.

Test Plan:
- Reset, then 5 ticks with DIV=12 while STOPPED -> time stays 12:00:00 AM, running=0, set_ready=1.
- start=1, then 12 ticks -> sec=8'h01, exactly one sec_pulse, prescaler back to 0; 11 more ticks -> sec still 01.
- DIV=1: set 11:59 AM, start, then 60 ticks -> hour=8'h12, min=8'h00, sec=8'h00, pm=1, one hour_pulse.
- DIV=1: set 12:59 PM, then 60 ticks -> hour=8'h01, pm stays 1; set 11:59 PM, then 60 ticks -> 12:00:00, pm=0.
- set_valid with hour=8'h13, then hour=8'h00, then min=8'h5A -> set_err pulses each time, time unchanged; set_valid while RUNNING -> set_ready=0, no load.
- Running at 03:27:45 PM, assert neg_clear between clock edges -> outputs read 12:00:00 AM, running=0 before the next edge; start and stop together -> stays STOPPED.

Source files
------------

// File: rtl/twelve_hour_timekeeper_pkg.sv
// Shared constants, FSM state type and BCD time-legality check for the timekeeper.
package timekeeper_pkg;

    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HOUR_MIN = 8'h01;
    localparam logic [7:0] HOUR_MAX = 8'h12;
    localparam logic [7:0] HOUR_RST = 8'h12;

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    // True when every digit is 0..9, hour is 01..12 and minute is 00..59.
    // Once the digits are valid, plain hex ordering matches decimal ordering.
    function automatic logic bcd_time_legal(input logic [7:0] h, input logic [7:0] m);
        logic digits_ok;
        digits_ok = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
                    (m[7:4] <= 4'd9) && (m[3:0] <= 4'd9);
        return digits_ok && (h >= HOUR_MIN) && (h <= HOUR_MAX) && (m <= MIN_MAX);
    endfunction

endpackage

// File: rtl/twelve_hour_timekeeper_if.sv
// Time-load handshake: the loader offers hour/min/pm, the timekeeper answers
// with ready and a one-cycle error pulse for rejected values.
interface twelve_hour_timekeeper_if;
    logic       set_valid;
    logic       set_ready;
    logic [7:0] set_hour;
    logic [7:0] set_min;
    logic       set_pm;
    logic       set_err;

    modport master (output set_valid, set_hour, set_min, set_pm,
                    input  set_ready, set_err);
    modport slave  (input  set_valid, set_hour, set_min, set_pm,
                    output set_ready, set_err);
endinterface

// File: rtl/twelve_hour_timekeeper_bcd_pair_counter.sv
// Two-digit BCD counter running LO..HI and wrapping back to LO.
// Synchronous load has priority over the count enable; carry marks the
// enabled step out of HI so the next stage can chain on it.
module bcd_pair_counter #(
    parameter logic [7:0] LO  = 8'h00,
    parameter logic [7:0] HI  = 8'h59,
    parameter logic [7:0] RST = 8'h00
) (
    input  logic       clk,
    input  logic       neg_clear,
    input  logic       en,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [7:0] value,
    output logic       carry
);

    assign carry = en && (value == HI);

    // Load, or step one BCD count with units rolling 9 -> 0 into the tens digit.
    always_ff @(posedge clk or negedge neg_clear) begin
        if (!neg_clear) begin
            value <= RST;
        end else if (load) begin
            value <= load_val;
        end else if (en) begin
            if (value == HI)
                value <= LO;
            else if (value[3:0] == 4'd9)
                value <= {value[7:4] + 4'd1, 4'd0};
            else
                value <= {value[7:4], value[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/twelve_hour_timekeeper.sv
// 12-hour BCD timekeeper: run/stop FSM, tick prescaler, sec/min/hour counter
// chain, AM/PM flag and a load port that is only open while stopped.
module twelve_hour_timekeeper
    import timekeeper_pkg::*;
#(
    parameter int DIV = 12
) (
    input  logic                          clk,
    input  logic                          neg_clear,
    input  logic                          tick,
    input  logic                          start,
    input  logic                          stop,
    twelve_hour_timekeeper_if.slave       set_bus,
    output logic [7:0]                    hour,
    output logic [7:0]                    min,
    output logic [7:0]                    sec,
    output logic                          pm,
    output logic                          running,
    output logic                          sec_pulse,
    output logic                          hour_pulse
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] presc;
    logic          fire;
    logic          legal;
    logic          load_ok;
    logic          adv;
    logic          sec_carry;
    logic          min_carry;
    logic          hour_wrap;
    logic          pm_toggle;

    assign running           = (state == ST_RUNNING);
    assign set_bus.set_ready = (state == ST_STOPPED);
    assign fire              = set_bus.set_valid && set_bus.set_ready;
    assign legal             = bcd_time_legal(set_bus.set_hour, set_bus.set_min);
    assign load_ok           = fire && legal;
    assign adv               = running && tick && (presc == PRESC_LAST);
    // The 12 -> 01 wrap must never flip AM/PM; only the 11 -> 12 step does.
    assign pm_toggle         = min_carry && !hour_wrap && (hour == 8'h11);

    // State register.
    always_ff @(posedge clk or negedge neg_clear) begin
        if (!neg_clear) state <= ST_STOPPED;
        else            state <= state_next;
    end

    // Next state: stop dominates start.
    always_comb begin
        state_next = state;
        case (state)
            ST_STOPPED: if (start && !stop) state_next = ST_RUNNING;
            ST_RUNNING: if (stop)           state_next = ST_STOPPED;
            default:                        state_next = ST_STOPPED;
        endcase
    end

    // Prescaler: counts ticks only while running, cleared by a legal load.
    always_ff @(posedge clk or negedge neg_clear) begin
        if (!neg_clear)
            presc <= '0;
        else if (load_ok)
            presc <= '0;
        else if (running && tick)
            presc <= adv ? '0 : presc + 1'b1;
    end

    // AM/PM flag, event pulses and the load-error pulse.
    always_ff @(posedge clk or negedge neg_clear) begin
        if (!neg_clear) begin
            pm          <= 1'b0;
            sec_pulse   <= 1'b0;
            hour_pulse  <= 1'b0;
            set_bus.set_err <= 1'b0;
        end else begin
            sec_pulse       <= adv;
            hour_pulse      <= min_carry;
            set_bus.set_err <= fire && !legal;
            if (load_ok)
                pm <= set_bus.set_pm;
            else if (pm_toggle)
                pm <= !pm;
        end
    end

    bcd_pair_counter #(.LO(8'h00), .HI(SEC_MAX), .RST(8'h00)) u_sec (
        .clk(clk), .neg_clear(neg_clear), .en(adv), .load(load_ok),
        .load_val(8'h00), .value(sec), .carry(sec_carry)
    );

    bcd_pair_counter #(.LO(8'h00), .HI(MIN_MAX), .RST(8'h00)) u_min (
        .clk(clk), .neg_clear(neg_clear), .en(sec_carry), .load(load_ok),
        .load_val(set_bus.set_min), .value(min), .carry(min_carry)
    );

    bcd_pair_counter #(.LO(HOUR_MIN), .HI(HOUR_MAX), .RST(HOUR_RST)) u_hour (
        .clk(clk), .neg_clear(neg_clear), .en(min_carry), .load(load_ok),
        .load_val(set_bus.set_hour), .value(hour), .carry(hour_wrap)
    );

endmodule

// File: tb/tb_twelve_hour_timekeeper.sv
// Bench for the 12-hour timekeeper: two instances (DIV=12 and DIV=1) share one
// stimulus stream; a seconds-of-day model predicts every output each cycle.
module tb_twelve_hour_timekeeper;

    localparam int DIV_A = 12;
    localparam int DIV_B = 1;

    logic clk = 1'b0;
    logic neg_clear = 1'b0;
    logic tick = 1'b0, start = 1'b0, stop = 1'b0;
    logic sv = 1'b0, spm = 1'b0;
    logic [7:0] sh = 8'h00, sm = 8'h00;

    logic [7:0] hour_a, min_a, sec_a, hour_b, min_b, sec_b;
    logic pm_a, run_a, sp_a, hp_a, pm_b, run_b, sp_b, hp_b;

    int n_checks = 0;
    int n_fail = 0;
    int sp_cnt_a = 0;
    int hp_cnt_b = 0;

    always #5 clk = ~clk;

    twelve_hour_timekeeper_if if_a();
    twelve_hour_timekeeper_if if_b();

    assign if_a.set_valid = sv;  assign if_b.set_valid = sv;
    assign if_a.set_hour  = sh;  assign if_b.set_hour  = sh;
    assign if_a.set_min   = sm;  assign if_b.set_min   = sm;
    assign if_a.set_pm    = spm; assign if_b.set_pm    = spm;

    twelve_hour_timekeeper #(.DIV(DIV_A)) dut_a (
        .clk(clk), .neg_clear(neg_clear), .tick(tick), .start(start), .stop(stop),
        .set_bus(if_a.slave), .hour(hour_a), .min(min_a), .sec(sec_a), .pm(pm_a),
        .running(run_a), .sec_pulse(sp_a), .hour_pulse(hp_a)
    );

    twelve_hour_timekeeper #(.DIV(DIV_B)) dut_b (
        .clk(clk), .neg_clear(neg_clear), .tick(tick), .start(start), .stop(stop),
        .set_bus(if_b.slave), .hour(hour_b), .min(min_b), .sec(sec_b), .pm(pm_b),
        .running(run_b), .sec_pulse(sp_b), .hour_pulse(hp_b)
    );

    // Model: time as seconds since midnight (0 = 12:00:00 AM).
    typedef struct {
        int t;
        int presc;
        bit run;
        bit err;
        bit sp;
        bit hp;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_reset();
        mdl_t x;
        x.t = 0; x.presc = 0; x.run = 0; x.err = 0; x.sp = 0; x.hp = 0;
        return x;
    endfunction

    function automatic bit legal_time(logic [7:0] h, logic [7:0] m);
        int hh, hl, mh, ml;
        hh = h[7:4]; hl = h[3:0]; mh = m[7:4]; ml = m[3:0];
        if (hh > 9 || hl > 9 || mh > 9 || ml > 9) return 0;
        return (hh * 10 + hl >= 1) && (hh * 10 + hl <= 12) && (mh * 10 + ml <= 59);
    endfunction

    function automatic mdl_t mdl_step(mdl_t x, int div, bit tk, bit st, bit sp,
                                      bit v, logic [7:0] h, logic [7:0] m, bit p);
        mdl_t y;
        int hr, mn;
        y = x; y.err = 0; y.sp = 0; y.hp = 0;
        if (!x.run) begin
            if (v) begin
                if (legal_time(h, m)) begin
                    hr = h[7:4] * 10 + h[3:0];
                    mn = m[7:4] * 10 + m[3:0];
                    y.t = ((hr % 12) + (p ? 12 : 0)) * 3600 + mn * 60;
                    y.presc = 0;
                end else begin
                    y.err = 1;
                end
            end
            if (st && !sp) y.run = 1;
        end else begin
            if (tk) begin
                if (x.presc == div - 1) begin
                    y.presc = 0;
                    y.sp = 1;
                    if (x.t % 3600 == 3599) y.hp = 1;
                    y.t = (x.t + 1) % 86400;
                end else begin
                    y.presc = x.presc + 1;
                end
            end
            if (sp) y.run = 0;
        end
        return y;
    endfunction

    function automatic logic [7:0] to_bcd(int n);
        return 8'(((n / 10) << 4) | (n % 10));
    endfunction

    function automatic logic [7:0] exp_hour(int t);
        int h12;
        h12 = (t / 3600) % 12;
        return to_bcd(h12 == 0 ? 12 : h12);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Advance the model on the same edges the DUTs use.
    always @(posedge clk or negedge neg_clear) begin
        if (!neg_clear) begin
            ma = mdl_reset();
            mb = mdl_reset();
        end else begin
            ma = mdl_step(ma, DIV_A, tick, start, stop, sv, sh, sm, spm);
            mb = mdl_step(mb, DIV_B, tick, start, stop, sv, sh, sm, spm);
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("a_hour", 32'(hour_a), 32'(exp_hour(ma.t)));
        check("a_min",  32'(min_a),  32'(to_bcd((ma.t / 60) % 60)));
        check("a_sec",  32'(sec_a),  32'(to_bcd(ma.t % 60)));
        check("a_pm",   32'(pm_a),   32'(ma.t >= 43200));
        check("a_running", 32'(run_a), 32'(ma.run));
        check("a_set_ready", 32'(if_a.set_ready), 32'(!ma.run));
        check("a_set_err", 32'(if_a.set_err), 32'(ma.err));
        check("a_sec_pulse", 32'(sp_a), 32'(ma.sp));
        check("a_hour_pulse", 32'(hp_a), 32'(ma.hp));
        check("b_hour", 32'(hour_b), 32'(exp_hour(mb.t)));
        check("b_min",  32'(min_b),  32'(to_bcd((mb.t / 60) % 60)));
        check("b_sec",  32'(sec_b),  32'(to_bcd(mb.t % 60)));
        check("b_pm",   32'(pm_b),   32'(mb.t >= 43200));
        check("b_running", 32'(run_b), 32'(mb.run));
        check("b_set_ready", 32'(if_b.set_ready), 32'(!mb.run));
        check("b_set_err", 32'(if_b.set_err), 32'(mb.err));
        check("b_sec_pulse", 32'(sp_b), 32'(mb.sp));
        check("b_hour_pulse", 32'(hp_b), 32'(mb.hp));
        if (sp_a) sp_cnt_a++;
        if (hp_b) hp_cnt_b++;
    end

    task automatic step(input bit tk, input bit st, input bit sp);
        @(posedge clk); #2;
        tick = tk; start = st; stop = sp; sv = 1'b0;
    endtask

    task automatic set_time(input logic [7:0] h, input logic [7:0] m, input bit p);
        @(posedge clk); #2;
        tick = 1'b0; start = 1'b0; stop = 1'b0;
        sv = 1'b1; sh = h; sm = m; spm = p;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1, 0, 0);
        step(0, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic check_b_time(input string tag, input logic [7:0] h, input logic [7:0] m,
                                input logic [7:0] s, input bit p);
        check({tag, "_hour"}, 32'(hour_b), 32'(h));
        check({tag, "_min"},  32'(min_b),  32'(m));
        check({tag, "_sec"},  32'(sec_b),  32'(s));
        check({tag, "_pm"},   32'(pm_b),   32'(p));
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #2;
        check_b_time("rst", 8'h12, 8'h00, 8'h00, 1'b0);
        check("rst_hour_a", 32'(hour_a), 32'h12);
        check("rst_running_a", 32'(run_a), 32'h0);
        neg_clear = 1'b1;

        // Ticks while stopped are ignored
        repeat (5) step(1, 0, 0);
        step(0, 0, 0); step(0, 0, 0);
        check("stopped_hour_a", 32'(hour_a), 32'h12);
        check("stopped_sec_a", 32'(sec_a), 32'h00);
        check("stopped_running_a", 32'(run_a), 32'h0);
        check("stopped_ready_a", 32'(if_a.set_ready), 32'h1);

        // DIV=12: 12 ticks -> one second, 11 more -> still one second
        step(0, 1, 0);
        sp_cnt_a = 0;
        ticks(12);
        check("div12_sec", 32'(sec_a), 32'h01);
        check("div12_pulses", 32'(sp_cnt_a), 32'd1);
        ticks(11);
        check("div12_sec_hold", 32'(sec_a), 32'h01);

        // DIV=1: 11:59 AM + 60 s -> 12:00:00 PM
        step(0, 0, 1);
        set_time(8'h11, 8'h59, 1'b0);
        step(0, 1, 0);
        hp_cnt_b = 0;
        ticks(60);
        check_b_time("noon", 8'h12, 8'h00, 8'h00, 1'b1);
        check("noon_hour_pulses", 32'(hp_cnt_b), 32'd1);

        // 12:59 PM -> 01:00 PM, pm unchanged
        step(0, 0, 1);
        set_time(8'h12, 8'h59, 1'b1);
        step(0, 1, 0);
        ticks(60);
        check_b_time("one_pm", 8'h01, 8'h00, 8'h00, 1'b1);

        // 11:59 PM -> 12:00:00 AM
        step(0, 0, 1);
        set_time(8'h11, 8'h59, 1'b1);
        step(0, 1, 0);
        ticks(60);
        check_b_time("midnight", 8'h12, 8'h00, 8'h00, 1'b0);

        // Illegal loads pulse set_err for one cycle and leave time alone
        step(0, 0, 1);
        set_time(8'h13, 8'h00, 1'b0);
        step(0, 0, 0);
        check("err_h13", 32'(if_b.set_err), 32'h1);
        step(0, 0, 0);
        check("err_h13_clear", 32'(if_b.set_err), 32'h0);
        set_time(8'h00, 8'h30, 1'b1);
        step(0, 0, 0);
        check("err_h00", 32'(if_b.set_err), 32'h1);
        set_time(8'h10, 8'h5A, 1'b1);
        step(0, 0, 0);
        check("err_m5a", 32'(if_a.set_err), 32'h1);
        step(0, 0, 0);
        check_b_time("err_keep", 8'h12, 8'h00, 8'h00, 1'b0);

        // Load attempt while running is not accepted
        step(0, 1, 0);
        set_time(8'h05, 8'h05, 1'b1);
        check("run_ready_b", 32'(if_b.set_ready), 32'h0);
        step(0, 0, 0);
        step(0, 0, 0);
        check_b_time("run_noload", 8'h12, 8'h00, 8'h00, 1'b0);
        step(0, 0, 1);

        // Randomised traffic, checked cycle by cycle against the model
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #2;
            tick  = 1'($urandom_range(0, 1));
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 31) == 0);
            sv    = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 3) == 0) begin
                sh = 8'($urandom);
                sm = 8'($urandom);
            end else begin
                sh = to_bcd($urandom_range(0, 13));
                sm = to_bcd($urandom_range(0, 60));
            end
            spm = 1'($urandom_range(0, 1));
        end

        // Reset between edges while running at 03:27:45 PM
        step(0, 0, 1);
        set_time(8'h03, 8'h27, 1'b1);
        step(0, 1, 0);
        ticks(45);
        check_b_time("pre_rst", 8'h03, 8'h27, 8'h45, 1'b1);
        @(posedge clk); #2;
        neg_clear = 1'b0;
        #1;
        check_b_time("async_rst", 8'h12, 8'h00, 8'h00, 1'b0);
        check("async_rst_running", 32'(run_b), 32'h0);
        @(posedge clk); #2;
        neg_clear = 1'b1;

        // start and stop together: stays stopped
        step(0, 1, 1);
        step(0, 0, 0);
        check("start_stop_a", 32'(run_a), 32'h0);
        check("start_stop_b", 32'(run_b), 32'h0);
        step(0, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
